// File: rtl/pcie_wrapper.sv
// pcie_wrapper: self-contained AXI4 read/write subsystem standing in for the
// host/PCIe memory window. A start/done command interface drives an AXI4
// burst master. The master talks to an internal AXI4 slave that is backed by
// a DATA_W-wide on-chip memory of 2**MEM_AW words.
//
// Ports:
//   ACLK_0          in   single clock, rising edge
//   ARESETN_0       in   asynchronous active-low reset
//   WR_START_0      in   one-cycle write command strobe
//   WR_ADRS_0       in   write byte address (sampled with WR_START_0)
//   WR_DATA_IN_0    in   DATA_W*BEATS write payload, beat k = bits [32k+31:32k]
//   WR_DONE_0       out  one-cycle pulse on write response
//   RD_START_0      in   one-cycle read command strobe
//   RD_ADRS_0       in   read byte address (sampled with RD_START_0)
//   RD_DATA_0       out  registered read beat; holds the last beat when idle
//   RD_DATA_VALID_0 out  high for each cycle RD_DATA_0 carries a new beat
//   RD_DONE_0       out  one-cycle pulse together with the last read beat
//   dbg_mst_state   out  master FSM state (debug)
//   dbg_slv_state   out  slave FSM state (debug)
//
// Handshakes: every internal AXI channel transfers on a rising edge where
// VALID and READY are both high. VALID, once raised, stays high with stable
// payload until that edge; READY may be high before VALID. Here all VALID and
// READY signals are pure functions of FSM state, so no channel has a
// combinational path from VALID to READY.
module pcie_wrapper #(
  parameter int DATA_W = 32,
  parameter int BEATS  = 8,
  parameter int MEM_AW = 8
) (
  input  logic                      ACLK_0,
  input  logic                      ARESETN_0,
  input  logic                      WR_START_0,
  input  logic [31:0]               WR_ADRS_0,
  input  logic [DATA_W*BEATS-1:0]   WR_DATA_IN_0,
  output logic                      WR_DONE_0,
  input  logic                      RD_START_0,
  input  logic [31:0]               RD_ADRS_0,
  output logic [DATA_W-1:0]         RD_DATA_0,
  output logic                      RD_DATA_VALID_0,
  output logic                      RD_DONE_0,
  output logic [2:0]                dbg_mst_state,
  output logic [2:0]                dbg_slv_state
);

  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int STRBW = DATA_W / 8;

  typedef enum logic [2:0] {
    M_IDLE  = 3'd0,
    M_WADDR = 3'd1,
    M_WDATA = 3'd2,
    M_WRESP = 3'd3,
    M_RADDR = 3'd4,
    M_RDATA = 3'd5
  } mst_state_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WDATA  = 3'd1,
    S_WRESP  = 3'd2,
    S_RFETCH = 3'd3,
    S_RDATA  = 3'd4
  } slv_state_t;

  // ---------------------------------------------------------------------------
  // Internal AXI4 link
  // ---------------------------------------------------------------------------
  logic [31:0]       awaddr, araddr;
  logic [7:0]        awlen, arlen;
  logic [2:0]        awsize, arsize;
  logic [1:0]        awburst, arburst;
  logic              awvalid, awready, arvalid, arready;
  logic [DATA_W-1:0] wdata;
  logic [STRBW-1:0]  wstrb;
  logic              wlast, wvalid, wready;
  logic [1:0]        bresp;
  logic              bvalid, bready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast, rvalid, rready;

  // ---------------------------------------------------------------------------
  // Master
  // ---------------------------------------------------------------------------
  mst_state_t                mst_state, mst_next;
  logic [31:0]               addr_q;
  logic [DATA_W*BEATS-1:0]   data_q;
  logic [BW-1:0]             beat;

  always_ff @(posedge ACLK_0 or negedge ARESETN_0) begin
    if (!ARESETN_0) mst_state <= M_IDLE;
    else            mst_state <= mst_next;
  end

  always_comb begin
    mst_next = mst_state;
    case (mst_state)
      M_IDLE: begin
        // Write wins when both strobes arrive together; the read is dropped.
        if (WR_START_0)      mst_next = M_WADDR;
        else if (RD_START_0) mst_next = M_RADDR;
      end
      M_WADDR: if (awready)                   mst_next = M_WDATA;
      M_WDATA: if (wready && wlast)           mst_next = M_WRESP;
      M_WRESP: if (bvalid)                    mst_next = M_IDLE;
      M_RADDR: if (arready)                   mst_next = M_RDATA;
      M_RDATA: if (rvalid && rlast)           mst_next = M_IDLE;
      default:                                mst_next = M_IDLE;
    endcase
  end

  assign awaddr  = addr_q;
  assign araddr  = addr_q;
  assign awlen   = 8'(BEATS - 1);
  assign arlen   = 8'(BEATS - 1);
  assign awsize  = 3'd2;   // 4-byte beats
  assign arsize  = 3'd2;
  assign awburst = 2'b01;  // INCR
  assign arburst = 2'b01;
  assign awvalid = (mst_state == M_WADDR);
  assign arvalid = (mst_state == M_RADDR);
  assign wvalid  = (mst_state == M_WDATA);
  // Payload is shifted down one beat per W transfer, so beat k is always at
  // the bottom of the register when it is presented.
  assign wdata   = data_q[DATA_W-1:0];
  assign wstrb   = '1;
  assign wlast   = (beat == BW'(BEATS - 1));
  assign bready  = 1'b1;
  assign rready  = 1'b1;

  always_ff @(posedge ACLK_0 or negedge ARESETN_0) begin
    if (!ARESETN_0) begin
      addr_q          <= '0;
      data_q          <= '0;
      beat            <= '0;
      WR_DONE_0       <= 1'b0;
      RD_DATA_0       <= '0;
      RD_DATA_VALID_0 <= 1'b0;
      RD_DONE_0       <= 1'b0;
    end else begin
      WR_DONE_0       <= 1'b0;
      RD_DATA_VALID_0 <= 1'b0;
      RD_DONE_0       <= 1'b0;
      case (mst_state)
        M_IDLE: begin
          beat <= '0;
          if (WR_START_0) begin
            addr_q <= WR_ADRS_0;
            data_q <= WR_DATA_IN_0;
          end else if (RD_START_0) begin
            addr_q <= RD_ADRS_0;
          end
        end
        M_WDATA: begin
          if (wready) begin
            data_q <= data_q >> DATA_W;
            beat   <= beat + BW'(1);
          end
        end
        M_WRESP: begin
          if (bvalid) WR_DONE_0 <= 1'b1;
        end
        M_RDATA: begin
          if (rvalid) begin
            RD_DATA_0       <= rdata;
            RD_DATA_VALID_0 <= 1'b1;
            RD_DONE_0       <= rlast;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Slave with on-chip memory
  // ---------------------------------------------------------------------------
  slv_state_t          slv_state, slv_next;
  logic [MEM_AW-1:0]   wptr;    // current word index, wraps at end of memory
  logic [7:0]          cnt;
  logic [7:0]          len;
  logic [DATA_W-1:0]   mem [2**MEM_AW];

  always_ff @(posedge ACLK_0 or negedge ARESETN_0) begin
    if (!ARESETN_0) slv_state <= S_IDLE;
    else            slv_state <= slv_next;
  end

  always_comb begin
    slv_next = slv_state;
    case (slv_state)
      S_IDLE: begin
        if (awvalid)      slv_next = S_WDATA;
        else if (arvalid) slv_next = S_RFETCH;
      end
      S_WDATA:  if (wvalid && wlast)  slv_next = S_WRESP;
      S_WRESP:  if (bready)           slv_next = S_IDLE;
      S_RFETCH:                       slv_next = S_RDATA;
      S_RDATA:  if (rready && rlast)  slv_next = S_IDLE;
      default:                        slv_next = S_IDLE;
    endcase
  end

  assign awready = (slv_state == S_IDLE);
  assign arready = (slv_state == S_IDLE) && !awvalid;
  assign wready  = (slv_state == S_WDATA);
  assign bvalid  = (slv_state == S_WRESP);
  assign bresp   = 2'b00;
  assign rvalid  = (slv_state == S_RDATA);
  assign rresp   = 2'b00;
  assign rlast   = (slv_state == S_RDATA) && (cnt == len);

  // Memory is synchronous: the first beat is fetched in S_RFETCH, and each R
  // transfer prefetches the next word so rdata is ready one cycle later.
  always_ff @(posedge ACLK_0 or negedge ARESETN_0) begin
    if (!ARESETN_0) begin
      wptr  <= '0;
      cnt   <= '0;
      len   <= '0;
      rdata <= '0;
    end else begin
      case (slv_state)
        S_IDLE: begin
          cnt <= '0;
          if (awvalid) begin
            wptr <= awaddr[MEM_AW+1:2];
          end else if (arvalid) begin
            wptr <= araddr[MEM_AW+1:2];
            len  <= arlen;
          end
        end
        S_WDATA: begin
          if (wvalid) wptr <= wptr + MEM_AW'(1);
        end
        S_RFETCH: begin
          rdata <= mem[wptr];
          wptr  <= wptr + MEM_AW'(1);
        end
        S_RDATA: begin
          if (rready) begin
            cnt   <= cnt + 8'd1;
            rdata <= mem[wptr];
            wptr  <= wptr + MEM_AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge ACLK_0) begin
    if (wvalid && wready) begin
      for (int b = 0; b < STRBW; b++) begin
        if (wstrb[b]) mem[wptr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // The slave implements only INCR bursts of 4-byte beats with OKAY
  // responses, and decodes only the word-index bits of the address.
  logic unused_axi;
  assign unused_axi = ^{awaddr[31:MEM_AW+2], awaddr[1:0], araddr[31:MEM_AW+2],
                        araddr[1:0], awlen, awsize, arsize, awburst, arburst,
                        bresp, rresp};

  assign dbg_mst_state = mst_state;
  assign dbg_slv_state = slv_state;

endmodule

// File: tb/tb_pcie_wrapper.sv
// Testbench for pcie_wrapper: directed cases plus randomized write/read pairs
// checked against a word-array model of the memory window.
module tb_pcie_wrapper;

  localparam int DATA_W    = 32;
  localparam int BEATS     = 8;
  localparam int MEM_AW    = 8;
  localparam int MEM_WORDS = 256;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    wr_start;
  logic [31:0]             wr_adrs;
  logic [DATA_W*BEATS-1:0] wr_data;
  logic                    wr_done;
  logic                    rd_start;
  logic [31:0]             rd_adrs;
  logic [DATA_W-1:0]       rd_data;
  logic                    rd_valid;
  logic                    rd_done;
  logic [2:0]              dbg_mst;
  logic [2:0]              dbg_slv;

  always #5 clk = ~clk;

  pcie_wrapper #(.DATA_W(DATA_W), .BEATS(BEATS), .MEM_AW(MEM_AW)) dut (
    .ACLK_0          (clk),
    .ARESETN_0       (rst_n),
    .WR_START_0      (wr_start),
    .WR_ADRS_0       (wr_adrs),
    .WR_DATA_IN_0    (wr_data),
    .WR_DONE_0       (wr_done),
    .RD_START_0      (rd_start),
    .RD_ADRS_0       (rd_adrs),
    .RD_DATA_0       (rd_data),
    .RD_DATA_VALID_0 (rd_valid),
    .RD_DONE_0       (rd_done),
    .dbg_mst_state   (dbg_mst),
    .dbg_slv_state   (dbg_slv)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard and reference model
  // ---------------------------------------------------------------------------
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] mem_model [MEM_WORDS];
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Word k of a burst at byte address addr lands at this memory word.
  function automatic int unsigned word_idx(input logic [31:0] addr, input int k);
    int unsigned a;
    a = addr;
    return ((a / 4) + k) % MEM_WORDS;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [DATA_W*BEATS-1:0] data);
    for (int k = 0; k < BEATS; k++) mem_model[word_idx(addr, k)] = data[32*k +: 32];
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // mode 0: plain write; 1: RD_START together with WR_START; 2: RD_START
  // pulsed on sample rd_at during the write.
  task automatic do_write(input logic [31:0] addr, input logic [DATA_W*BEATS-1:0] data,
                          input int mode, input int rd_at);
    int done_cnt;
    int done_pos;
    int rd_act;
    done_cnt = 0;
    done_pos = -1;
    rd_act   = 0;
    @(negedge clk);
    wr_adrs  = addr;
    wr_data  = data;
    wr_start = 1'b1;
    if (mode == 1) begin
      rd_adrs  = addr ^ 32'h40;
      rd_start = 1'b1;
    end
    @(negedge clk);
    wr_start = 1'b0;
    rd_start = 1'b0;
    for (int s = 0; s < 16; s++) begin
      if (s > 0) @(negedge clk);
      if (wr_done) begin
        done_cnt++;
        if (done_pos < 0) done_pos = s;
      end
      if (rd_valid || rd_done) rd_act++;
      if (mode == 2 && s == rd_at) begin
        rd_adrs  = addr;
        rd_start = 1'b1;
      end else begin
        rd_start = 1'b0;
      end
    end
    model_write(addr, data);
    check("wr_done_count", done_cnt, 1);
    check("wr_done_latency", done_pos, 10);
    check("wr_no_rd_activity", rd_act, 0);
  endtask

  task automatic do_read(input logic [31:0] addr);
    int v_cnt;
    int first_v;
    int last_v;
    int done_cnt;
    int done_pos;
    logic [31:0] last_exp;
    v_cnt    = 0;
    first_v  = -1;
    last_v   = -1;
    done_cnt = 0;
    done_pos = -1;
    exp_q.delete();
    for (int k = 0; k < BEATS; k++) exp_q.push_back(mem_model[word_idx(addr, k)]);
    last_exp = mem_model[word_idx(addr, BEATS - 1)];
    @(negedge clk);
    rd_adrs  = addr;
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    for (int s = 0; s < 16; s++) begin
      if (s > 0) @(negedge clk);
      if (rd_valid) begin
        v_cnt++;
        if (first_v < 0) first_v = s;
        last_v = s;
        if (exp_q.size() > 0) check("rd_beat", rd_data, exp_q.pop_front());
        else                  check("rd_extra_beat", {31'd0, rd_valid}, 32'd0);
      end
      if (rd_done) begin
        done_cnt++;
        if (done_pos < 0) done_pos = s;
      end
    end
    check("rd_valid_count", v_cnt, BEATS);
    check("rd_first_valid", first_v, 3);
    check("rd_last_valid", last_v, 10);
    check("rd_done_count", done_cnt, 1);
    check("rd_done_with_last", done_pos, 10);
    check("rd_data_hold", rd_data, last_exp);
  endtask

  // Expects no done or read-valid activity for n cycles.
  task automatic quiet_cycles(input string tag, input int n);
    int act;
    act = 0;
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      if (wr_done || rd_valid || rd_done) act++;
    end
    check(tag, act, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wr_done"}, {31'd0, wr_done}, 32'd0);
    check({tag, "_rd_data"}, rd_data, 32'd0);
    check({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
    check({tag, "_rd_done"}, {31'd0, rd_done}, 32'd0);
    check({tag, "_mst_idle"}, {29'd0, dbg_mst}, 32'd0);
    check({tag, "_slv_idle"}, {29'd0, dbg_slv}, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [DATA_W*BEATS-1:0] d;
    logic [31:0]             a;
    rst_n    = 1'b0;
    wr_start = 1'b0;
    wr_adrs  = '0;
    wr_data  = '0;
    rd_start = 1'b0;
    rd_adrs  = '0;

    // Reset held 1000 ns with start pulses that must be ignored.
    #300;
    @(negedge clk); wr_start = 1'b1; wr_adrs = 32'h10;
    @(negedge clk); wr_start = 1'b0; rd_start = 1'b1;
    @(negedge clk); rd_start = 1'b0;
    #672;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs_zero("post_reset");
    quiet_cycles("reset_starts_ignored", 15);

    // Directed write / read-back at an aliased high address.
    d = 256'hDEADBEEF_CAFEBABE_11223344_55667788_99AABBCC_DDEEFF00_12345678_9ABCDEF0;
    do_write(32'hC000_0000, d, 0, 0);
    do_read(32'hC000_0000);
    do_read(32'h0000_0000);

    // Burst wrapping past the end of memory.
    for (int k = 0; k < BEATS; k++) d[32*k +: 32] = $urandom();
    do_write(32'h0000_03F8, d, 0, 0);
    do_read(32'h0000_03F8);
    do_read(32'h0000_0000);

    // Simultaneous strobes: only the write runs.
    for (int k = 0; k < BEATS; k++) d[32*k +: 32] = $urandom();
    do_write(32'h0000_0100, d, 1, 0);
    quiet_cycles("dropped_read_stays_dropped", 12);
    do_read(32'h0000_0100);

    // Read strobe during a write is ignored.
    for (int k = 0; k < BEATS; k++) d[32*k +: 32] = $urandom();
    do_write(32'h0000_0200, d, 2, 4);
    quiet_cycles("mid_write_read_ignored", 12);

    // Reset in the middle of a read aborts it without a done pulse.
    @(negedge clk);
    rd_adrs  = 32'h0000_03F8;
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("mid_read_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    quiet_cycles("aborted_read_no_done", 15);
    do_read(32'h0000_03F8);
    do_read(32'h0000_0200);

    // Randomized write/read pairs, including aliased upper address bits.
    for (int it = 0; it < 16; it++) begin
      a = {$urandom_range(0, 15), 20'd0, 8'($urandom_range(0, MEM_WORDS - 1)), 2'b00};
      for (int k = 0; k < BEATS; k++) d[32*k +: 32] = $urandom();
      do_write(a, d, 0, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_read(a);
      if ($urandom_range(0, 1) == 1) do_read(a ^ 32'h8000_0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
